spi_slave_core: RTL and testbench



---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_input_synchronizer.sv | 49 ++++
 rtl/spi_slave_core.sv | 156 +++++++++++++++
 tb/tb_spi_slave_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state type, mode encodings and sizing helper for the SPI slave core.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Mode number to {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_input_synchronizer.sv
// Brings SCLK, CS_n and MOSI into the clock domain; edges appear SYNC_STAGES+1 clocks after the pin.
// Always accepts; no back-pressure.
module spi_input_synchronizer
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sclk_leading_o,
  output logic sclk_trailing_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  // Each stage holds {sclk, cs_n, mosi}
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        sclk_prev_q;
  logic                        cs_prev_q;
  logic                        sclk_s;
  logic                        cs_s;

  assign sclk_s = sync_q[SYNC_STAGES-1][2];
  assign cs_s   = sync_q[SYNC_STAGES-1][1];
  assign mosi_o = sync_q[SYNC_STAGES-1][0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= {SYNC_STAGES{{CPOL, 1'b1, 1'b0}}};
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], {sclk_i, cs_n_i, mosi_i}};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_leading_o  = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign sclk_trailing_o = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign cs_fall_o       = cs_prev_q && !cs_s;
  assign cs_rise_o       = !cs_prev_q && cs_s;

endmodule

// File: rtl/spi_slave_core.sv
// Full-duplex SPI slave, any CPOL/CPHA, configurable width and bit order; rx_valid 2 clocks after last sample edge.
// tx side is a one-word ready/valid holding register; rx has no back-pressure and is overwritten.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(32'hACDC1112)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  serial_clock,
  input  logic                  chip_select,
  input  logic                  serial_in,
  output logic                  serial_out,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int unsigned      CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] WORD_END = CNT_W'(DATA_WIDTH);

  logic mosi_s, sclk_leading, sclk_trailing, cs_fall, cs_rise;

  spi_input_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .CPOL        (CPOL)
  ) u_sync (
    .clock           (clock),
    .reset_n         (reset_n),
    .sclk_i          (serial_clock),
    .cs_n_i          (chip_select),
    .mosi_i          (serial_in),
    .mosi_o          (mosi_s),
    .sclk_leading_o  (sclk_leading),
    .sclk_trailing_o (sclk_trailing),
    .cs_fall_o       (cs_fall),
    .cs_rise_o       (cs_rise)
  );

  spi_state_t            state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q, rx_shift_q, rx_data_q, hold_q;
  logic                  rx_valid_q, tx_underrun_q, frame_abort_q;
  logic                  reload_pending_q, first_shift_q, hold_full_q;

  logic                  sample_edge, shift_edge, word_done, active_edge;
  logic                  load_word, tx_accept;
  logic [DATA_WIDTH-1:0] load_dat, rx_shift_d, tx_shift_d;

  assign sample_edge = CPHA ? sclk_trailing : sclk_leading;
  assign shift_edge  = CPHA ? sclk_leading : sclk_trailing;
  assign word_done   = (state_q == ACTIVE) && (bit_cnt_q == WORD_END);
  // A CS rise in the same cycle as an SCLK edge masks the edge
  assign active_edge = (state_q == ACTIVE) && !cs_rise && !word_done;

  assign load_word = ((state_q == IDLE) && cs_fall)
                   || (word_done && CPHA)
                   || (active_edge && shift_edge && !CPHA && reload_pending_q);
  assign load_dat  = hold_full_q ? hold_q : DEFAULT_TX;
  assign tx_accept = tx_valid && !hold_full_q;

  assign rx_shift_d = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};

  // A load in the accept cycle sees the register still empty, so the new word waits for the next load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (load_word && hold_full_q) begin
      hold_full_q <= 1'b0;
    end else if (tx_accept) begin
      hold_q      <= tx_data;
      hold_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      bit_cnt_q        <= '0;
      tx_shift_q       <= '0;
      rx_shift_q       <= '0;
      rx_data_q        <= '0;
      rx_valid_q       <= 1'b0;
      tx_underrun_q    <= 1'b0;
      frame_abort_q    <= 1'b0;
      reload_pending_q <= 1'b0;
      first_shift_q    <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      if (load_word) begin
        tx_shift_q    <= load_dat;
        first_shift_q <= 1'b1;
        tx_underrun_q <= !hold_full_q;
      end
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q          <= ACTIVE;
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (word_done) begin
            rx_data_q        <= rx_shift_q;
            rx_valid_q       <= 1'b1;
            bit_cnt_q        <= '0;
            reload_pending_q <= !CPHA;
          end
          if (cs_rise) begin
            state_q          <= IDLE;
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
            frame_abort_q    <= (bit_cnt_q != '0) && !word_done;
          end else if (active_edge && sample_edge) begin
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
          end else if (active_edge && shift_edge) begin
            // First CPHA=1 shift edge, or a CPHA=0 reload, leaves the freshly loaded word in place
            if (CPHA ? first_shift_q : reload_pending_q) begin
              first_shift_q    <= 1'b0;
              reload_pending_q <= 1'b0;
            end else begin
              tx_shift_q <= tx_shift_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_out  = chip_select ? 1'bz
                     : (MSB_FIRST ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0]);
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: one mode-0/32-bit slave, three more modes, and an 8-bit LSB-first slave on a shared SPI master.
`timescale 1ns/1ps
module tb_spi_slave_core;

  localparam int HALF = 60;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic [4:0]  cs_n = 5'b11111;
  logic [4:0]  tx_valid = 5'b00000;
  logic [31:0] tx_data = 32'h0;

  wire         miso0, miso8;
  wire [3:1]   miso_m;
  wire [4:0]   tx_ready, rx_valid, tx_underrun, frame_abort;
  wire [3:0][31:0] rx32;
  wire [7:0]   rx8;

  pullup (miso0);

  int checks = 0;
  int errors = 0;
  int n_rxv [5];
  int n_und [5];
  int n_abt [5];
  logic [31:0] rx_hist0 [$];

  always #5 clock = ~clock;

  spi_slave_core #(.DATA_WIDTH(32), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_m0 (
    .clock(clock), .reset_n(reset_n), .serial_clock(sclk), .chip_select(cs_n[0]),
    .serial_in(mosi), .serial_out(miso0), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx32[0]), .rx_valid(rx_valid[0]),
    .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0])
  );

  for (genvar m = 1; m < 4; m++) begin : g_mode
    spi_slave_core #(.DATA_WIDTH(32), .CPOL(bit'(m / 2)), .CPHA(bit'(m % 2)), .MSB_FIRST(1'b1),
                     .SYNC_STAGES(2)) u_mx (
      .clock(clock), .reset_n(reset_n), .serial_clock(sclk), .chip_select(cs_n[m]),
      .serial_in(mosi), .serial_out(miso_m[m]), .tx_data(tx_data), .tx_valid(tx_valid[m]),
      .tx_ready(tx_ready[m]), .rx_data(rx32[m]), .rx_valid(rx_valid[m]),
      .tx_underrun(tx_underrun[m]), .frame_abort(frame_abort[m])
    );
  end

  spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_lsb8 (
    .clock(clock), .reset_n(reset_n), .serial_clock(sclk), .chip_select(cs_n[4]),
    .serial_in(mosi), .serial_out(miso8), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]), .rx_data(rx8), .rx_valid(rx_valid[4]),
    .tx_underrun(tx_underrun[4]), .frame_abort(frame_abort[4])
  );

  always @(negedge clock) begin
    for (int k = 0; k < 5; k++) begin
      n_rxv[k] += int'(rx_valid[k]);
      n_und[k] += int'(tx_underrun[k]);
      n_abt[k] += int'(frame_abort[k]);
    end
    if (rx_valid[0]) rx_hist0.push_back(rx32[0]);
  end

  function automatic logic miso_of(input int idx);
    case (idx)
      0:       return miso0;
      1:       return miso_m[1];
      2:       return miso_m[2];
      3:       return miso_m[3];
      default: return miso8;
    endcase
  endfunction

  // end_mode: 0 = raise CS half a period after the last edge, 1 = raise CS with the last edge, 2 = leave CS low
  task automatic spi_xfer(input int idx, input bit cpol, input bit cpha, input int nbits,
                          input logic [63:0] mosi_w, input bit lsb, input int end_mode,
                          output logic [63:0] miso_w);
    int b;
    miso_w = '0;
    sclk = cpol;
    #100;
    cs_n[idx] = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = mosi_w[b];
        #HALF;
        sclk = !cpol;
        miso_w[b] = miso_of(idx);
        #HALF;
        sclk = cpol;
        if (i == nbits - 1 && end_mode == 1) cs_n[idx] = 1'b1;
      end else begin
        sclk = !cpol;
        mosi = mosi_w[b];
        #HALF;
        sclk = cpol;
        miso_w[b] = miso_of(idx);
        #HALF;
      end
    end
    if (end_mode == 0) begin
      #HALF;
      cs_n[idx] = 1'b1;
    end
    #HALF;
  endtask

  task automatic push_tx(input int idx, input logic [31:0] w);
    tx_data = w;
    tx_valid[idx] = 1'b1;
    @(posedge clock);
    #1;
    tx_valid[idx] = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rx32[0] !== 32'h0) begin errors++; $display("FAIL reset_rx_data got %h want %h", rx32[0], 32'h0); end
    checks++; if (rx_valid !== 5'b0) begin errors++; $display("FAIL reset_rx_valid got %b want %b", rx_valid, 5'b0); end
    checks++; if (tx_underrun !== 5'b0) begin errors++; $display("FAIL reset_underrun got %b want %b", tx_underrun, 5'b0); end
    checks++; if (frame_abort !== 5'b0) begin errors++; $display("FAIL reset_abort got %b want %b", frame_abort, 5'b0); end
    checks++; if (tx_ready !== 5'b11111) begin errors++; $display("FAIL reset_tx_ready got %b want %b", tx_ready, 5'b11111); end
  endtask

  task automatic test_mode0_underrun();
    logic [63:0] mi;
    int rxv0, und0;
    @(negedge clock);
    rxv0 = n_rxv[0]; und0 = n_und[0];
    spi_xfer(0, 1'b0, 1'b0, 32, 64'h12345678, 1'b0, 1, mi);
    checks++; if (mi[31:0] !== 32'hACDC1112) begin errors++; $display("FAIL m0_miso got %h want %h", mi[31:0], 32'hACDC1112); end
    checks++; if (n_und[0] - und0 !== 1) begin errors++; $display("FAIL m0_underrun_pulses got %0d want 1", n_und[0] - und0); end
    checks++; if (n_rxv[0] - rxv0 !== 1) begin errors++; $display("FAIL m0_rx_valid_pulses got %0d want 1", n_rxv[0] - rxv0); end
    checks++; if (rx32[0] !== 32'h12345678) begin errors++; $display("FAIL m0_rx_data got %h want %h", rx32[0], 32'h12345678); end
  endtask

  task automatic test_modes_123();
    logic [63:0] mi;
    for (int m = 1; m < 4; m++) begin
      push_tx(m, 32'hDEADBEEF);
      checks++; if (tx_ready[m] !== 1'b0) begin errors++; $display("FAIL mode%0d_ready_held got %b want 0", m, tx_ready[m]); end
      spi_xfer(m, bit'(m / 2), bit'(m % 2), 32, 64'hA5A5F00F, 1'b0, (m % 2 == 1) ? 0 : 1, mi);
      checks++; if (mi[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL mode%0d_miso got %h want %h", m, mi[31:0], 32'hDEADBEEF); end
      checks++; if (rx32[m] !== 32'hA5A5F00F) begin errors++; $display("FAIL mode%0d_rx_data got %h want %h", m, rx32[m], 32'hA5A5F00F); end
      checks++; if (tx_ready[m] !== 1'b1) begin errors++; $display("FAIL mode%0d_ready_after got %b want 1", m, tx_ready[m]); end
    end
  endtask

  task automatic test_lsb_first();
    logic [63:0] mi;
    int rxv0;
    rxv0 = n_rxv[4];
    push_tx(4, 32'h00000001);
    spi_xfer(4, 1'b0, 1'b0, 8, 64'h80, 1'b1, 1, mi);
    checks++; if (mi[0] !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b want 1", mi[0]); end
    checks++; if (mi[7:0] !== 8'h01) begin errors++; $display("FAIL lsb_miso got %h want %h", mi[7:0], 8'h01); end
    checks++; if (rx8 !== 8'h80) begin errors++; $display("FAIL lsb_rx_data got %h want %h", rx8, 8'h80); end
    checks++; if (n_rxv[4] - rxv0 !== 1) begin errors++; $display("FAIL lsb_rx_valid_pulses got %0d want 1", n_rxv[4] - rxv0); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] mi;
    int rxv0, und0, h0, t;
    rxv0 = n_rxv[0]; und0 = n_und[0]; h0 = rx_hist0.size();
    push_tx(0, 32'h11111111);
    fork
      spi_xfer(0, 1'b0, 1'b0, 64, {32'hCAFEF00D, 32'h13579BDF}, 1'b0, 1, mi);
      begin
        t = 0;
        while (tx_ready[0] !== 1'b1 && t < 2000) begin
          @(negedge clock);
          t++;
        end
        checks++; if (t >= 2000) begin errors++; $display("FAIL b2b_ready_timeout got %0d cycles want <2000", t); end
        else push_tx(0, 32'h22222222);
      end
    join
    checks++; if (mi !== {32'h11111111, 32'h22222222}) begin errors++; $display("FAIL b2b_miso got %h want %h", mi, {32'h11111111, 32'h22222222}); end
    checks++; if (n_rxv[0] - rxv0 !== 2) begin errors++; $display("FAIL b2b_rx_valid_pulses got %0d want 2", n_rxv[0] - rxv0); end
    checks++; if (n_und[0] - und0 !== 0) begin errors++; $display("FAIL b2b_underrun_pulses got %0d want 0", n_und[0] - und0); end
    checks++; if (rx_hist0.size() != h0 + 2 || rx_hist0[h0] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rx_word1 got %0d words want word %h", rx_hist0.size() - h0, 32'hCAFEF00D); end
    checks++; if (rx32[0] !== 32'h13579BDF) begin errors++; $display("FAIL b2b_rx_word2 got %h want %h", rx32[0], 32'h13579BDF); end
  endtask

  task automatic test_abort();
    logic [63:0] mi;
    int rxv0, abt0;
    rxv0 = n_rxv[0]; abt0 = n_abt[0];
    push_tx(0, 32'h00000000);
    spi_xfer(0, 1'b0, 1'b0, 13, 64'h1FFF, 1'b0, 2, mi);
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL abort_miso_driven got %b want 0", miso0); end
    cs_n[0] = 1'b1;
    #1;
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL abort_miso_released got %b want 1 (pulled)", miso0); end
    #199;
    checks++; if (n_abt[0] - abt0 !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", n_abt[0] - abt0); end
    checks++; if (n_rxv[0] - rxv0 !== 0) begin errors++; $display("FAIL abort_rx_valid_pulses got %0d want 0", n_rxv[0] - rxv0); end
    checks++; if (rx32[0] !== 32'h13579BDF) begin errors++; $display("FAIL abort_rx_kept got %h want %h", rx32[0], 32'h13579BDF); end
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_tx_ready got %b want 1", tx_ready[0]); end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] mi;
    int rxv0, und0;
    @(negedge clock);
    push_tx(0, 32'hFFFFFFFF);
    spi_xfer(0, 1'b0, 1'b0, 20, 64'hABCDE, 1'b0, 2, mi);
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL rst_mid_miso_before got %b want 1", miso0); end
    push_tx(0, 32'h00000000);
    checks++; if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_hold_full got %b want 0", tx_ready[0]); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rst_mid_miso got %b want 0", miso0); end
    checks++; if (rx32[0] !== 32'h0) begin errors++; $display("FAIL rst_mid_rx_data got %h want %h", rx32[0], 32'h0); end
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready got %b want 1", tx_ready[0]); end
    checks++; if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_valid got %b want 0", rx_valid[0]); end
    cs_n[0] = 1'b1;
    @(negedge clock);
    #50;
    reset_n = 1'b1;
    #50;
    rxv0 = n_rxv[0]; und0 = n_und[0];
    spi_xfer(0, 1'b0, 1'b0, 32, 64'h0F0F1234, 1'b0, 1, mi);
    checks++; if (mi[31:0] !== 32'hACDC1112) begin errors++; $display("FAIL rst_after_miso got %h want %h", mi[31:0], 32'hACDC1112); end
    checks++; if (rx32[0] !== 32'h0F0F1234) begin errors++; $display("FAIL rst_after_rx_data got %h want %h", rx32[0], 32'h0F0F1234); end
    checks++; if (n_rxv[0] - rxv0 !== 1) begin errors++; $display("FAIL rst_after_rx_valid_pulses got %0d want 1", n_rxv[0] - rxv0); end
    checks++; if (n_und[0] - und0 !== 1) begin errors++; $display("FAIL rst_after_underrun_pulses got %0d want 1", n_und[0] - und0); end
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      n_rxv[k] = 0;
      n_und[k] = 0;
      n_abt[k] = 0;
    end
    repeat (3) @(negedge clock);
    test_reset();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    test_mode0_underrun();
    test_modes_123();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
